// File: rtl/fft_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// fft_frame_sequencer_if
//   Bundles the SPI frame/result handshakes and the streaming FFT core signals
//   seen by fft_frame_sequencer.
//   master : SPI register block + FFT core (drive frames, FFT results, acks)
//   slave  : the sequencer itself
// Signals
//   frame_in/frame_valid/frame_ready   wide real-sample frame handshake
//   fft_busy                           FFT core still processing
//   fft_in/fft_load/fft_idx/fft_start  sample stream into the FFT
//   fft_out/fft_out_valid              result stream out of the FFT
//   result/result_valid/result_ack     gathered result frame handshake
//   err                                sticky stray-result flag
// ---------------------------------------------------------------------------
interface fft_frame_sequencer_if #(
    parameter int N  = 64,
    parameter int SW = 16
);
    localparam int IW = $clog2(N);

    logic [N*SW-1:0]   frame_in;
    logic              frame_valid;
    logic              frame_ready;
    logic              fft_busy;
    logic [2*SW-1:0]   fft_in;
    logic              fft_load;
    logic [IW-1:0]     fft_idx;
    logic              fft_start;
    logic [2*SW-1:0]   fft_out;
    logic              fft_out_valid;
    logic [2*N*SW-1:0] result;
    logic              result_valid;
    logic              result_ack;
    logic              err;

    modport master (
        output frame_in, frame_valid, fft_busy, fft_out, fft_out_valid, result_ack,
        input  frame_ready, fft_in, fft_load, fft_idx, fft_start, result, result_valid, err
    );

    modport slave (
        input  frame_in, frame_valid, fft_busy, fft_out, fft_out_valid, result_ack,
        output frame_ready, fft_in, fft_load, fft_idx, fft_start, result, result_valid, err
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// fft_frame_sequencer
//   Captures one wide frame of N real samples, streams them to the FFT core as
//   complex words {re, 0} (one per clock), pulses fft_start, then gathers N
//   complex FFT output words into a wide result frame held for SPI readback.
// Ports
//   clk    system clock, all logic on posedge
//   reset  asynchronous, active-low reset
//   bus    fft_frame_sequencer_if.slave (frame, FFT stream, result, err)
// Parameters
//   N          samples per frame (power of 2, >= 4)
//   SW         real sample width; FFT word is 2*SW bits {re, im}
//   MSB_FIRST  1: sample/word 0 in the frame MSBs; 0: in the LSBs
// ---------------------------------------------------------------------------
module fft_frame_sequencer #(
    parameter int N         = 64,
    parameter int SW        = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_frame_sequencer_if.slave  bus
);
    localparam int            IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [2:0] {IDLE, SEND, START, COLLECT, HOLD} state_t;

    state_t                     state, state_next;
    logic [IW-1:0]              idx;
    logic [IW-1:0]              idx_inc;
    logic [IW-1:0]              slot;
    logic [N-1:0][SW-1:0]       frame_q;
    logic [N-1:0][2*SW-1:0]     result_q;
    logic                       err_q;
    logic                       capture;
    logic                       collect_step;
    logic                       stray;

    // Packed slot k of both frames sits at [k*W +: W]; MSB_FIRST reverses it.
    assign slot    = MSB_FIRST ? (LAST - idx) : idx;
    // Terminal compare against N-1 so idx never wraps on its own.
    assign idx_inc = (idx == LAST) ? '0 : idx + IW'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal written here gets a default first; a missing branch
    // would otherwise infer a latch.
    always_comb begin
        state_next       = state;
        capture          = 1'b0;
        collect_step     = 1'b0;
        stray            = 1'b0;
        bus.frame_ready  = 1'b0;
        bus.fft_load     = 1'b0;
        bus.fft_in       = '0;
        bus.fft_start    = 1'b0;
        bus.result_valid = 1'b0;

        case (state)
            IDLE: begin
                bus.frame_ready = 1'b1;
                if (bus.frame_valid && !bus.fft_busy) begin
                    capture    = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                bus.fft_load = 1'b1;
                bus.fft_in   = {frame_q[slot], {SW{1'b0}}};
                if (idx == LAST) state_next = START;
            end
            START: begin
                bus.fft_start = 1'b1;
                state_next    = COLLECT;
            end
            COLLECT: begin
                if (bus.fft_out_valid) begin
                    collect_step = 1'b1;
                    if (idx == LAST) state_next = HOLD;
                end
            end
            HOLD: begin
                bus.result_valid = 1'b1;
                if (bus.result_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Results arriving while not collecting are dropped and flagged.
        if (bus.fft_out_valid && state != COLLECT) stray = 1'b1;
    end

    // NOTE: the wide sample and result registers are reset as well, so a
    // readback before the first FFT run returns zeros rather than X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx      <= '0;
            frame_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (capture) begin
                frame_q <= bus.frame_in;
                idx     <= '0;
            end
            if (state == SEND) idx <= idx_inc;
            if (collect_step) begin
                result_q[slot] <= bus.fft_out;
                idx            <= idx_inc;
            end
            if (stray) err_q <= 1'b1;
        end
    end

    assign bus.fft_idx = idx;
    assign bus.result  = result_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_sequencer
//   Directed bench for fft_frame_sequencer: a 64-sample MSB-first instance and
//   an 8-sample LSB-first instance, each on its own interface.
// ---------------------------------------------------------------------------
module tb_fft_frame_sequencer;
    localparam int N  = 64;
    localparam int N8 = 8;
    localparam int SW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fft_frame_sequencer_if #(.N(N),  .SW(SW)) bus  ();
    fft_frame_sequencer_if #(.N(N8), .SW(SW)) bus8 ();

    fft_frame_sequencer #(.N(N),  .SW(SW), .MSB_FIRST(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus));
    fft_frame_sequencer #(.N(N8), .SW(SW), .MSB_FIRST(1'b0)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0][2*SW-1:0]  exp_res;
    logic [N8-1:0][2*SW-1:0] exp_res8;

    // Frame for the MSB-first instance: sample k = base + k at [(N-k)*SW-1 -: SW].
    function automatic logic [N*SW-1:0] make_frame(input logic [15:0] base);
        logic [N*SW-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) f[(N-1-k)*SW +: SW] = 16'(base + k);
        return f;
    endfunction

    // Waits for fft_start, feeds N words (base + k*step) back-to-back, records
    // them in exp_res and waits for result_valid. Expired bounds count as failures.
    task automatic run_collect(input logic [31:0] base, input logic [31:0] step);
        int c;
        c = 0;
        while (bus.fft_start !== 1'b1 && c < 200) begin @(negedge clk); c++; end
        n_checks++;
        if (bus.fft_start !== 1'b1) begin
            n_fail++; $display("FAIL start_timeout: fft_start=%b want 1", bus.fft_start);
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            bus.fft_out         = base + 32'(k) * step;
            bus.fft_out_valid   = 1'b1;
            exp_res[N-1-k]      = base + 32'(k) * step;
            @(negedge clk);
        end
        bus.fft_out_valid = 1'b0;
        c = 0;
        while (bus.result_valid !== 1'b1 && c < 20) begin @(negedge clk); c++; end
        n_checks++;
        if (bus.result_valid !== 1'b1) begin
            n_fail++; $display("FAIL result_timeout: result_valid=%b want 1", bus.result_valid);
        end
    endtask

    task automatic ack_result();
        bus.result_ack = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #11;
        n_checks++;
        if (bus.frame_ready !== 1'b1 || bus.fft_load !== 1'b0 || bus.fft_start !== 1'b0 ||
            bus.result_valid !== 1'b0 || bus.err !== 1'b0 || bus.fft_in !== '0 || bus.fft_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b load=%b start=%b rv=%b err=%b in=%h idx=%0d want 1,0,0,0,0,0,0",
                     bus.frame_ready, bus.fft_load, bus.fft_start, bus.result_valid, bus.err, bus.fft_in, bus.fft_idx);
        end
        n_checks++;
        if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result: result not zero, want 0"); end
        @(negedge clk);
        reset = 1'b1;

        // Start a frame, then pull reset part-way through SEND.
        bus.frame_in    = make_frame(16'h0100);
        bus.frame_valid = 1'b1;
        @(negedge clk);
        bus.frame_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.fft_load !== 1'b1 || bus.fft_idx !== 6'd2) begin
            n_fail++; $display("FAIL midsend_pre: load=%b idx=%0d want 1,2", bus.fft_load, bus.fft_idx);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.frame_ready !== 1'b1 || bus.fft_load !== 1'b0 || bus.fft_idx !== '0 || bus.fft_in !== '0) begin
            n_fail++;
            $display("FAIL midsend_abort: ready=%b load=%b idx=%0d in=%h want 1,0,0,0",
                     bus.frame_ready, bus.fft_load, bus.fft_idx, bus.fft_in);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.fft_start !== 1'b0) begin n_fail++; $display("FAIL midsend_start: fft_start=%b want 0", bus.fft_start); end
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.fft_start !== 1'b0 || bus.frame_ready !== 1'b1 || bus.fft_load !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: start=%b ready=%b load=%b want 0,1,0", bus.fft_start, bus.frame_ready, bus.fft_load);
        end
    endtask

    task automatic test_send();
        bus.frame_in    = make_frame(16'h0001);
        bus.frame_valid = 1'b1;
        @(negedge clk);
        bus.frame_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (bus.fft_load !== 1'b1 || bus.fft_in !== {16'(k + 1), 16'h0000} ||
                bus.fft_idx !== 6'(k) || bus.fft_start !== 1'b0) begin
                n_fail++;
                $display("FAIL send_load[%0d]: load=%b in=%h idx=%0d start=%b want 1,%h,%0d,0",
                         k, bus.fft_load, bus.fft_in, bus.fft_idx, bus.fft_start, {16'(k + 1), 16'h0000}, k);
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.fft_load !== 1'b0 || bus.fft_start !== 1'b1) begin
            n_fail++; $display("FAIL send_start: load=%b start=%b want 0,1", bus.fft_load, bus.fft_start);
        end
        @(negedge clk);
        n_checks++;
        if (bus.fft_start !== 1'b0 || bus.frame_ready !== 1'b0 || bus.fft_idx !== '0) begin
            n_fail++;
            $display("FAIL send_single_pulse: start=%b ready=%b idx=%0d want 0,0,0", bus.fft_start, bus.frame_ready, bus.fft_idx);
        end
    endtask

    // Continues from COLLECT left by test_send; valid every other cycle.
    task automatic test_collect();
        logic [31:0] slot5;
        logic [2*N*SW-1:0] res_v;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (bus.fft_idx !== 6'(k) || bus.result_valid !== 1'b0) begin
                n_fail++; $display("FAIL collect_idx[%0d]: idx=%0d rv=%b want %0d,0", k, bus.fft_idx, bus.result_valid, k);
            end
            bus.fft_out       = 32'(k) * 32'h0001_0001;
            bus.fft_out_valid = 1'b1;
            exp_res[N-1-k]    = 32'(k) * 32'h0001_0001;
            @(negedge clk);
            bus.fft_out_valid = 1'b0;
            if (k != N - 1) @(negedge clk);
        end
        n_checks++;
        if (bus.result_valid !== 1'b1 || bus.result !== exp_res) begin
            n_fail++; $display("FAIL collect_result: rv=%b result=%h want 1,%h", bus.result_valid, bus.result, exp_res);
        end
        res_v = bus.result;
        slot5 = res_v[(N-5)*2*SW-1 -: 2*SW];
        n_checks++;
        if (slot5 !== 32'h0005_0005) begin n_fail++; $display("FAIL collect_slot5: got %h want 00050005", slot5); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.result_valid !== 1'b1 || bus.frame_ready !== 1'b0 || bus.result !== exp_res) begin
                n_fail++; $display("FAIL hold[%0d]: rv=%b ready=%b result changed", i, bus.result_valid, bus.frame_ready);
            end
        end
        ack_result();
        n_checks++;
        if (bus.frame_ready !== 1'b1 || bus.result_valid !== 1'b0 || bus.result !== exp_res) begin
            n_fail++; $display("FAIL ack_release: ready=%b rv=%b want 1,0 (result must be kept)", bus.frame_ready, bus.result_valid);
        end
    endtask

    task automatic test_busy_hold();
        bus.fft_busy    = 1'b1;
        bus.frame_in    = make_frame(16'hA000);
        bus.frame_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.frame_ready !== 1'b1 || bus.fft_load !== 1'b0) begin
                n_fail++; $display("FAIL busy_hold[%0d]: ready=%b load=%b want 1,0", i, bus.frame_ready, bus.fft_load);
            end
        end
        bus.fft_busy = 1'b0;
        @(negedge clk);
        bus.frame_valid = 1'b0;
        n_checks++;
        if (bus.fft_load !== 1'b1 || bus.fft_in !== 32'hA000_0000 || bus.fft_idx !== '0) begin
            n_fail++; $display("FAIL busy_capture: load=%b in=%h idx=%0d want 1,a0000000,0", bus.fft_load, bus.fft_in, bus.fft_idx);
        end
        run_collect(32'h1000_0000, 32'h0000_0001);
        n_checks++;
        if (bus.result !== exp_res) begin n_fail++; $display("FAIL busy_result: got %h want %h", bus.result, exp_res); end
        ack_result();
    endtask

    task automatic test_err();
        n_checks++;
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_pre: err=%b want 0", bus.err); end
        bus.fft_out       = 32'hDEAD_BEEF;
        bus.fft_out_valid = 1'b1;
        @(negedge clk);
        bus.fft_out_valid = 1'b0;
        n_checks++;
        if (bus.err !== 1'b1 || bus.result !== exp_res || bus.frame_ready !== 1'b1) begin
            n_fail++; $display("FAIL err_set: err=%b ready=%b want 1,1 (result unchanged)", bus.err, bus.frame_ready);
        end
        bus.frame_in    = make_frame(16'h2000);
        bus.frame_valid = 1'b1;
        @(negedge clk);
        bus.frame_valid = 1'b0;
        n_checks++;
        if (bus.err !== 1'b1 || bus.fft_load !== 1'b1) begin
            n_fail++; $display("FAIL err_send: err=%b load=%b want 1,1", bus.err, bus.fft_load);
        end
        run_collect(32'h2222_0000, 32'h0000_0003);
        n_checks++;
        if (bus.err !== 1'b1 || bus.result !== exp_res) begin
            n_fail++; $display("FAIL err_frame: err=%b result=%h want 1,%h", bus.err, bus.result, exp_res);
        end
        ack_result();
        n_checks++;
        if (bus.err !== 1'b1 || bus.frame_ready !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: err=%b ready=%b want 1,1", bus.err, bus.frame_ready);
        end
    endtask

    task automatic test_lsb_first();
        logic [N8*SW-1:0] f;
        logic [2*N8*SW-1:0] r;
        f = '0;
        for (int k = 0; k < N8; k++) f[k*SW +: SW] = 16'(16'h1100 + k);
        bus8.frame_in    = f;
        bus8.frame_valid = 1'b1;
        @(negedge clk);
        bus8.frame_valid = 1'b0;
        for (int k = 0; k < N8; k++) begin
            n_checks++;
            if (bus8.fft_load !== 1'b1 || bus8.fft_in !== {16'(16'h1100 + k), 16'h0000} || bus8.fft_idx !== 3'(k)) begin
                n_fail++;
                $display("FAIL lsb_load[%0d]: load=%b in=%h idx=%0d want 1,%h,%0d",
                         k, bus8.fft_load, bus8.fft_in, bus8.fft_idx, {16'(16'h1100 + k), 16'h0000}, k);
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus8.fft_start !== 1'b1) begin n_fail++; $display("FAIL lsb_start: start=%b want 1", bus8.fft_start); end
        @(negedge clk);
        for (int k = 0; k < N8; k++) begin
            bus8.fft_out       = 32'hC0DE_0000 + 32'(k);
            bus8.fft_out_valid = 1'b1;
            exp_res8[k]        = 32'hC0DE_0000 + 32'(k);
            @(negedge clk);
        end
        bus8.fft_out_valid = 1'b0;
        r = bus8.result;
        n_checks++;
        if (bus8.result_valid !== 1'b1 || r[31:0] !== 32'hC0DE_0000 || r !== exp_res8) begin
            n_fail++; $display("FAIL lsb_result: rv=%b result=%h want 1,%h", bus8.result_valid, r, exp_res8);
        end
        bus8.result_ack = 1'b1;
        @(negedge clk);
        bus8.result_ack = 1'b0;
        n_checks++;
        if (bus8.frame_ready !== 1'b1 || bus8.err !== 1'b0) begin
            n_fail++; $display("FAIL lsb_release: ready=%b err=%b want 1,0", bus8.frame_ready, bus8.err);
        end
    endtask

    initial begin
        bus.frame_in = '0;  bus.frame_valid = 1'b0;  bus.fft_busy = 1'b0;
        bus.fft_out = '0;   bus.fft_out_valid = 1'b0; bus.result_ack = 1'b0;
        bus8.frame_in = '0; bus8.frame_valid = 1'b0; bus8.fft_busy = 1'b0;
        bus8.fft_out = '0;  bus8.fft_out_valid = 1'b0; bus8.result_ack = 1'b0;

        test_reset();
        test_send();
        test_collect();
        test_busy_hold();
        test_err();
        test_lsb_first();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
